// File: rtl/grayscale_2_raw_mosaic.sv
// Re-mosaics an 8-bit grayscale stream into a 10-bit raw Bayer stream with line/frame timing.
// Optional per-site gain stage (adds one cycle of latency) is enabled by defining BAYER_GAIN_EN.
module grayscale_2_raw_mosaic #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int HBLANK = 16,
    parameter int VBLANK = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_sof,
    input  logic [7:0] s_data,
    input  logic [3:0] gain_r,
    input  logic [3:0] gain_gr,
    input  logic [3:0] gain_gb,
    input  logic [3:0] gain_b,
    output logic [9:0] raw_data,
    output logic       enable,
    output logic       line_valid,
    output logic       frame_valid,
    output logic       sync_err
);

    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] col, col_next, pix_col;
    logic [RW-1:0] row, row_next, pix_row;
    logic [BW-1:0] blank_cnt, blank_next;
    logic          accept, restart, emit;

    logic [9:0]    s1_raw;
    logic          s1_en, s1_fv, s1_se;
    logic          frame_d;

    // Ready is held low while reset is asserted so the source sees no acceptance.
    assign s_ready = ~reset & ((state == ST_IDLE) | (state == ST_ACTIVE));
    assign accept  = s_valid & s_ready;
    assign restart = accept & s_sof;
    assign emit    = accept & (s_sof | (state == ST_ACTIVE));
    assign pix_col = restart ? '0 : col;
    assign pix_row = restart ? '0 : row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_next;
            col       <= col_next;
            row       <= row_next;
            blank_cnt <= blank_next;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        blank_next = blank_cnt;
        case (state)
            ST_IDLE, ST_ACTIVE: begin
                if (emit) begin
                    if (pix_col == COL_LAST) begin
                        col_next = '0;
                        if (pix_row == ROW_LAST) begin
                            row_next   = '0;
                            state_next = ST_VBLANK;
                            blank_next = BW'(VBLANK - 1);
                        end else begin
                            row_next   = pix_row + 1'b1;
                            state_next = ST_HBLANK;
                            blank_next = BW'(HBLANK - 1);
                        end
                    end else begin
                        col_next   = pix_col + 1'b1;
                        row_next   = pix_row;
                        state_next = ST_ACTIVE;
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_cnt == '0) state_next = ST_ACTIVE;
                else blank_next = blank_cnt - 1'b1;
            end
            ST_VBLANK: begin
                if (blank_cnt == '0) state_next = ST_IDLE;
                else blank_next = blank_cnt - 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // frame_valid stays up across stalls and horizontal blanking until the last pixel leaves.
    assign frame_d = emit | (s1_fv & ((state == ST_ACTIVE) | (state == ST_HBLANK)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_raw <= '0;
            s1_en  <= 1'b0;
            s1_fv  <= 1'b0;
            s1_se  <= 1'b0;
        end else begin
            if (emit) s1_raw <= {s_data, s_data[7:6]};
            s1_en <= emit;
            s1_fv <= frame_d;
            s1_se <= restart & (state == ST_ACTIVE);
        end
    end

`ifdef BAYER_GAIN_EN
    logic [3:0]  gain_site, s1_gain;
    logic [13:0] product;

    always_comb begin
        case ({pix_row[0], pix_col[0]})
            2'b00:   gain_site = gain_r;
            2'b01:   gain_site = gain_gr;
            2'b10:   gain_site = gain_gb;
            default: gain_site = gain_b;
        endcase
    end

    assign product = 14'(s1_raw) * 14'(s1_gain);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_gain     <= '0;
            raw_data    <= '0;
            enable      <= 1'b0;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            if (emit) s1_gain <= gain_site;
            // Product of 4096 or more would exceed 10 bits after the Q2.2 shift.
            if (s1_en) raw_data <= (|product[13:12]) ? 10'h3FF : product[11:2];
            enable      <= s1_en;
            line_valid  <= s1_en;
            frame_valid <= s1_fv;
            sync_err    <= s1_se;
        end
    end
`else
    logic unused_gain;
    assign unused_gain = ^{gain_r, gain_gr, gain_gb, gain_b};

    assign raw_data    = s1_raw;
    assign enable      = s1_en;
    assign line_valid  = s1_en;
    assign frame_valid = s1_fv;
    assign sync_err    = s1_se;
`endif

endmodule
